// File: rtl/lbist_controller_if.sv
// LBIST controller signal bundle: session request/signature in, TPG/MISR/scan strobes out.
// master = controller side, slave = test-mode wrapper / TPG / MISR side.
interface lbist_controller_if #(
    parameter int unsigned N_PATTERNS = 1000,
    parameter int unsigned LFSR_W     = 24,
    parameter int unsigned MISR_W     = 24
);
    localparam int unsigned PAT_W = $clog2(N_PATTERNS + 1);

    logic              start;
    logic [MISR_W-1:0] misr_sig;
    logic              lfsr_load;
    logic [LFSR_W-1:0] lfsr_seed;
    logic              lfsr_en;
    logic              misr_clr;
    logic              misr_en;
    logic              scan_en;
    logic              capture;
    logic              busy;
    logic              done;
    logic              pass;
    logic [PAT_W-1:0]  pat_idx;

    modport master (
        input  start, misr_sig,
        output lfsr_load, lfsr_seed, lfsr_en, misr_clr, misr_en, scan_en,
               capture, busy, done, pass, pat_idx
    );

    modport slave (
        output start, misr_sig,
        input  lfsr_load, lfsr_seed, lfsr_en, misr_clr, misr_en, scan_en,
               capture, busy, done, pass, pat_idx
    );
endinterface

// File: rtl/lbist_controller.sv
// LBIST session sequencer: seed load, N_PATTERNS shift/capture rounds, response flush,
// then a MISR signature compare. All outputs are decoded from registered state.
module lbist_controller #(
    parameter int unsigned      N_PATTERNS = 1000,
    parameter int unsigned      SCAN_LEN   = 267,
    parameter int unsigned      LFSR_W     = 24,
    parameter int unsigned      MISR_W     = 24,
    parameter logic [LFSR_W-1:0] SEED       = 24'h000001,
    parameter logic [MISR_W-1:0] GOLDEN_SIG = 24'h000000
) (
    input  logic clk,
    input  logic rst_n,
    lbist_controller_if.master bus
);
    localparam int unsigned PAT_W = $clog2(N_PATTERNS + 1);
    localparam int unsigned SC_W  = $clog2(SCAN_LEN + 1);

    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SCAN_LEN - 1);
    localparam logic [PAT_W-1:0] PAT_PRE  = PAT_W'(N_PATTERNS - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INIT    = 3'd1;
    localparam logic [2:0] S_SHIFT   = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_FLUSH   = 3'd4;
    localparam logic [2:0] S_COMPARE = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [SC_W-1:0]  shift_cnt_q, shift_cnt_d;
    logic [PAT_W-1:0] pat_cnt_q, pat_cnt_d;
    logic             pass_q, pass_d;

    always_comb begin
        state_d     = state_q;
        shift_cnt_d = shift_cnt_q;
        pat_cnt_d   = pat_cnt_q;
        pass_d      = pass_q;
        case (state_q)
            S_IDLE: begin
                // counters clear on INIT entry so pat_idx already reads 0 during INIT
                if (bus.start) begin
                    state_d     = S_INIT;
                    shift_cnt_d = '0;
                    pat_cnt_d   = '0;
                    pass_d      = 1'b0;
                end
            end
            S_INIT: begin
                state_d = bus.start ? S_SHIFT : S_IDLE;
            end
            S_SHIFT: begin
                if (!bus.start) begin
                    state_d = S_IDLE;
                end else if (shift_cnt_q == SC_LAST) begin
                    state_d     = S_CAPTURE;
                    shift_cnt_d = '0;
                end else begin
                    shift_cnt_d = shift_cnt_q + 1'b1;
                end
            end
            S_CAPTURE: begin
                if (!bus.start) begin
                    state_d = S_IDLE;
                end else begin
                    pat_cnt_d = pat_cnt_q + 1'b1;
                    state_d   = (pat_cnt_q == PAT_PRE) ? S_FLUSH : S_SHIFT;
                end
            end
            S_FLUSH: begin
                if (!bus.start) begin
                    state_d = S_IDLE;
                end else if (shift_cnt_q == SC_LAST) begin
                    state_d     = S_COMPARE;
                    shift_cnt_d = '0;
                end else begin
                    shift_cnt_d = shift_cnt_q + 1'b1;
                end
            end
            S_COMPARE: begin
                if (!bus.start) begin
                    state_d = S_IDLE;
                end else begin
                    pass_d  = (bus.misr_sig == GOLDEN_SIG);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!bus.start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            shift_cnt_q <= '0;
            pat_cnt_q   <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_cnt_q <= shift_cnt_d;
            pat_cnt_q   <= pat_cnt_d;
            pass_q      <= pass_d;
        end
    end

    // First window after INIT carries no response yet, so MISR stays idle while pat_cnt is 0
    assign bus.lfsr_load = (state_q == S_INIT);
    assign bus.misr_clr  = (state_q == S_INIT);
    assign bus.lfsr_seed = SEED;
    assign bus.lfsr_en   = (state_q == S_SHIFT);
    assign bus.scan_en   = (state_q == S_SHIFT) || (state_q == S_FLUSH);
    assign bus.misr_en   = ((state_q == S_SHIFT) && (pat_cnt_q != '0)) || (state_q == S_FLUSH);
    assign bus.capture   = (state_q == S_CAPTURE);
    assign bus.busy      = (state_q == S_INIT)  || (state_q == S_SHIFT) || (state_q == S_CAPTURE) ||
                           (state_q == S_FLUSH) || (state_q == S_COMPARE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.pass      = (state_q == S_DONE) && pass_q;
    assign bus.pat_idx   = pat_cnt_q;
endmodule
